// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
// Sequential binary-to-BCD converter for the four-digit seven-segment mux.
// A value is accepted on start while idle and converted with a shift-and-add-3
// (double-dabble) loop, one input bit per clock. Results are registered and
// held until the next conversion completes. Values above 9999 clamp to 9999.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-high
//   start     in   conversion request, sampled only while idle
//   bin       in   unsigned binary value [IN_WIDTH-1:0], captured on accept
//   busy      out  conversion in progress
//   done      out  one-cycle pulse when new digits are valid
//   overflow  out  last accepted value exceeded 9999
//   digit0..3 out  BCD units, tens, hundreds, thousands
//
// State   | meaning
// S_IDLE  | waiting for start; outputs hold the last result
// S_SHIFT | one adjust/shift step per clock, r_cnt steps remaining

module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] bin,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [3:0]          digit0,
  output logic [3:0]          digit1,
  output logic [3:0]          digit2,
  output logic [3:0]          digit3
);

  localparam int                  CNT_W    = $clog2(IN_WIDTH + 1);
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(IN_WIDTH);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [IN_WIDTH-1:0] BCD_MAX  = IN_WIDTH'(9999);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t              r_state;
  logic [IN_WIDTH-1:0] r_bin;
  logic [15:0]         r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf_pend;

  logic [15:0]         w_adj;
  logic [15:0]         w_acc_next;
  logic [IN_WIDTH-1:0] w_bin_next;

  // Per-nibble add-3 correction; 4-bit adds so no carry crosses nibbles.
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < 4; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end
    end
  end

  // Accumulator bit 15 falls off the top; only possible for clamped values.
  assign w_acc_next = {w_adj[14:0], r_bin[IN_WIDTH-1]};
  assign w_bin_next = {r_bin[IN_WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      digit0     <= 4'd0;
      digit1     <= 4'd0;
      digit2     <= 4'd0;
      digit3     <= 4'd0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin      <= bin;
            r_acc      <= '0;
            r_ovf_pend <= (bin > BCD_MAX);
            r_cnt      <= CNT_LOAD;
            busy       <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_next;
          r_bin <= w_bin_next;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            // Last step goes straight to the outputs so the display never
            // sees a partially converted value.
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_IDLE;
            if (r_ovf_pend) begin
              digit0   <= 4'd9;
              digit1   <= 4'd9;
              digit2   <= 4'd9;
              digit3   <= 4'd9;
              overflow <= 1'b1;
            end else begin
              digit0   <= w_acc_next[3:0];
              digit1   <= w_acc_next[7:4];
              digit2   <= w_acc_next[11:8];
              digit3   <= w_acc_next[15:12];
              overflow <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] bin;
  logic         busy;
  logic         done;
  logic         overflow;
  logic [3:0]   digit0;
  logic [3:0]   digit1;
  logic [3:0]   digit2;
  logic [3:0]   digit3;

  typedef struct packed {
    logic [15:0] dig;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  int total     = 0;
  int bad       = 0;
  int cyc_cnt   = 0;
  int done_cnt  = 0;
  int busy_cnt  = 0;
  int acc_cyc   = 0;
  int busy_base = 0;

  wire [15:0] w_dig = {digit3, digit2, digit1, digit0};

  bin_to_bcd_seq #(.IN_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  // Reference result from decimal arithmetic, independent of the shift loop.
  function automatic exp_t model(int v);
    exp_t e;
    if (v > 9999) begin
      e.dig = 16'h9999;
      e.ovf = 1'b1;
    end else begin
      e.dig = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; the next edge accepts the request.
  task automatic accept(input int v);
    start = 1'b1;
    bin   = W'(v);
    @(posedge clk); #1;
    start     = 1'b0;
    acc_cyc   = cyc_cnt;
    busy_base = busy_cnt;
    sb.push_back(model(v));
  endtask

  // Waits (bounded) for done, then checks latency, busy span and the result.
  task automatic finish_conv(input string tag, input bit chk_hold, input logic [15:0] hold);
    int   n        = 0;
    int   hold_bad = 0;
    exp_t e;
    while (done !== 1'b1 && n < 40) begin
      if (chk_hold && w_dig !== hold) hold_bad++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(cyc_cnt - acc_cyc), 32'(W));
    check({tag, "_busy_cycles"}, 32'(busy_cnt - busy_base), 32'(W));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (chk_hold) check({tag, "_hold"}, 32'(hold_bad), 32'd0);
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_digits"}, 32'(w_dig), 32'(e.dig));
      check({tag, "_overflow"}, 32'(overflow), 32'(e.ovf));
    end
  endtask

  initial begin
    int d0;
    int vals[5] = '{0, 9999, 10000, 16383, 42};

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_digits", 32'(w_dig), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    accept(1234);
    finish_conv("c1234", 1'b1, 16'h0000);
    @(posedge clk); #1;
    check("c1234_done_one_cycle", 32'(done), 32'd0);

    // Each subsequent start lands in the previous done cycle.
    for (int i = 0; i < 5; i++) begin
      accept(vals[i]);
      finish_conv($sformatf("v%0d", vals[i]), 1'b0, 16'h0000);
    end
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;

    // Start pulsed mid-conversion must be ignored.
    d0 = done_cnt;
    accept(567);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    bin   = W'(888);
    @(posedge clk); #1;
    start = 1'b0;
    finish_conv("c567", 1'b1, 16'h0042);

    // Back-to-back accept in the done cycle; digits hold 0567 meanwhile.
    accept(8);
    finish_conv("c8", 1'b1, 16'h0567);
    @(posedge clk); #1;
    check("c8_done_one_cycle", 32'(done), 32'd0);
    check("c567_c8_done_count", 32'(done_cnt - d0), 32'd2);

    // Reset during cycle 7 of a conversion aborts it.
    accept(4321);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    check("abort_digits", 32'(w_dig), 32'd0);
    void'(sb.pop_back());
    d0 = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    accept(4321);
    finish_conv("c4321", 1'b1, 16'h0000);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter that feeds the four-digit seven-segment multiplexer. It accepts an unsigned binary value on a start/busy/done handshake and converts it with a shift-and-add-3 (double-dabble) loop, one bit per clock. It then presents four registered BCD digits, held stable until the next conversion completes. Values above 9999 clamp to 9999 and raise an overflow flag.

## Interface
- IN_WIDTH, 14: width of the binary input. Legal range is 14..16.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  conversion request; sampled only while idle.
- bin  input  IN_WIDTH  unsigned binary value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new digits are valid.
- overflow  output  1  last accepted value was > 9999; held until the next result.
- digit0  output  4  BCD units (LSB).
- digit1  output  4  BCD tens.
- digit2  output  4  BCD hundreds.
- digit3  output  4  BCD thousands (MSB).

## Operation
- States: IDLE and SHIFT.
- IDLE:
  - On start=1, capture bin into the shift register and clear the 16-bit BCD accumulator.
  - Latch ovf_pending = (bin > 9999).
  - Load the bit counter with IN_WIDTH, go to SHIFT.
- SHIFT, each cycle:
  - For each of the four accumulator nibbles that is >= 5, add 3 to it (nibbles handled independently, 4-bit add, no carry between nibbles).
  - Shift {accumulator, binary reg} left by one; the binary MSB enters accumulator bit 0.
  - Decrement the counter.
  - Bits shifted out of accumulator bit 15 are discarded; this only happens for values > 9999, which are clamped anyway.
- Final SHIFT cycle (counter = 1):
  - Compute the last adjust/shift combinationally and register it into the outputs.
  - If ovf_pending is set, the digits become 9,9,9,9 and overflow becomes 1.
  - Otherwise the digits take the accumulator nibbles and overflow becomes 0.
  - Assert done for one cycle and return to IDLE.
- Outputs digit0..3 and overflow change only on a done edge; between conversions they hold the previous result.
- start while busy=1: ignored; no queuing, no effect on the conversion in progress.
- bin changes while busy: no effect; the value is captured only at acceptance.

## Timing
- Reset values: busy=0, done=0, overflow=0, digit0..3=0, state=IDLE, internal registers cleared.
- Reset asserted mid-conversion:
  - Aborts immediately (asynchronous).
  - Outputs return to the reset values; no done pulse is produced.
- start is accepted at rising edge k:
  - busy=1 in cycles k+1 .. k+IN_WIDTH (IN_WIDTH cycles).
  - New digits, overflow and done=1 appear after edge k+IN_WIDTH.
  - Latency is IN_WIDTH cycles from the accepting edge (14 at default).
- During the done cycle busy=0 and the state is IDLE, so start=1 in that cycle is accepted (back-to-back throughput of one conversion per IN_WIDTH cycles).
- done is never asserted together with busy.
- done is high for exactly one cycle per accepted start.
- The downstream display may sample the digits at any time; they never show intermediate values.

## Test plan
- Reset, then start with bin=1234 (IN_WIDTH=14) -> busy high for 14 cycles; done after edge k+14; digit3..0 = 1,2,3,4; overflow=0.
- bin=0 -> digits 0,0,0,0 with overflow=0. Then bin=9999 -> digits 9,9,9,9 with overflow=0.
- bin=10000, then bin=16383 -> each gives digits 9,9,9,9 with overflow=1. Then bin=42 -> digits 0,0,4,2 and overflow clears to 0.
- Start with bin=567, then pulse start with bin=888 mid-conversion -> exactly one done; result 0,5,6,7.
- Start asserted again in the done cycle with bin=8 -> accepted; second done exactly 14 cycles later with 0,0,0,8; the digits hold 0,5,6,7 until then.
- Assert rst at cycle 7 of a conversion of 4321 -> outputs clear immediately; no done pulse; a subsequent start with 4321 completes normally to 4,3,2,1.
